// File: rtl/scan_chain_driver.sv
// scan_chain_driver: byte-fed serial scan chain shifter with an rx holding register.
// Optional capture loopback is compiled in with SCAN_CHAIN_DRIVER_LOOPBACK_EN.
module scan_chain_driver (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_start,
  input  logic [7:0] i_len,
  input  logic       i_abort,
  output logic       o_busy,
  output logic       o_done,
  input  logic [7:0] i_txData,
  input  logic       i_txValid,
  output logic       o_txReady,
  output logic [7:0] o_rxData,
  output logic       o_rxValid,
  input  logic       i_rxReady,
  output logic       o_chainIn,
  input  logic       i_chainOut,
  output logic       o_doShift,
  input  logic       i_driveReq,
  output logic       o_canDrive
`ifdef SCAN_CHAIN_DRIVER_LOOPBACK_EN
  ,
  input  logic       i_loopback
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_e;

  state_e     state_q;
  logic [7:0] len_q;
  logic [7:0] cnt_q;
  logic [7:0] tx_q;
  logic [7:0] acc_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       can_drive_q;

  logic [2:0] bit_idx;
  logic       last_bit;
  logic       byte_end;
  logic       stall;
  logic       shift_go;
  logic       tx_bit;
  logic       cap_bit;
  logic       start_go;
  logic [7:0] acc_d;

  assign bit_idx  = cnt_q[2:0];
  assign last_bit = (cnt_q == len_q);
  assign byte_end = (bit_idx == 3'd7) || last_bit;
  // Only a byte push can collide with a full holding register.
  assign stall    = (state_q == SHIFT) && byte_end
                    && rx_valid_q && !i_rxReady;
  assign shift_go = (state_q == SHIFT) && !stall;
  assign tx_bit   = tx_q[bit_idx];
  assign start_go = (state_q == IDLE) && i_start && !i_abort;

`ifdef SCAN_CHAIN_DRIVER_LOOPBACK_EN
  assign cap_bit   = i_loopback ? o_chainIn : i_chainOut;
  assign o_doShift = shift_go && !i_loopback;
`else
  assign cap_bit   = i_chainOut;
  assign o_doShift = shift_go;
`endif

  assign o_chainIn  = shift_go && tx_bit;
  assign o_busy     = (state_q == LOAD) || (state_q == SHIFT);
  assign o_txReady  = (state_q == LOAD);
  assign o_done     = (state_q == DONE);
  assign o_rxData   = rx_data_q;
  assign o_rxValid  = rx_valid_q;
  assign o_canDrive = can_drive_q;

  always_comb begin
    acc_d          = acc_q;
    acc_d[bit_idx] = cap_bit;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      tx_q        <= '0;
      acc_q       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      can_drive_q <= 1'b0;
    end else begin
      can_drive_q <= i_driveReq && (state_q == IDLE) && !start_go;
      if (i_abort) begin
        state_q    <= IDLE;
        rx_valid_q <= 1'b0;
      end else begin
        if (rx_valid_q && i_rxReady)
          rx_valid_q <= 1'b0;
        unique case (state_q)
          IDLE: begin
            if (i_start) begin
              len_q   <= i_len;
              cnt_q   <= '0;
              acc_q   <= '0;
              state_q <= LOAD;
            end
          end
          LOAD: begin
            if (i_txValid) begin
              tx_q    <= i_txData;
              state_q <= SHIFT;
            end
          end
          SHIFT: begin
            if (!stall) begin
              cnt_q <= cnt_q + 8'd1;
              if (byte_end) begin
                rx_data_q  <= acc_d;
                rx_valid_q <= 1'b1;
                acc_q      <= '0;
                state_q    <= last_bit ? DONE : LOAD;
              end else begin
                acc_q <= acc_d;
              end
            end
          end
          DONE: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/scan_chain_driver.md
SCAN_CHAIN_DRIVER -- requirements
Module: scan_chain_driver

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-low, with ports i_clk and i_rstn.
REQ-002 SHALL provide the following ports, one per line as name, direction, width, meaning:
- i_clk  in  1  system clock
- i_rstn  in  1  synchronous active-low reset
- i_start  in  1  begin a scan transfer
- i_len  in  8  transfer length in bits, minus 1 (range 1..256 bits)
- i_abort  in  1  cancel the current transfer
- o_busy  out  1  transfer in progress
- o_done  out  1  one-cycle pulse at transfer completion
- i_txData  in  8  next byte to shift into the chain
- i_txValid  in  1  i_txData is valid
- o_txReady  out  1  driver accepts i_txData this cycle
- o_rxData  out  8  captured chain byte
- o_rxValid  out  1  o_rxData is valid
- i_rxReady  in  1  consumer accepts o_rxData
- o_chainIn  out  1  serial data to the scan chain's shift input
- i_chainOut  in  1  serial data from the scan chain's shift output
- o_doShift  out  1  chain shift enable
- i_driveReq  in  1  host requests that the chain drive its probed lines
- o_canDrive  out  1  chain drive permission

Function
REQ-003 SHALL implement states IDLE, LOAD, SHIFT and DONE.
REQ-004 IDLE: o_busy=0; i_start latches i_len and enters LOAD next cycle; i_start in any other state SHALL be ignored.
REQ-005 LOAD: o_txReady=1; when i_txValid=1 the byte SHALL be captured and the state SHALL enter SHIFT next cycle; with no valid byte the state SHALL wait with no timeout.
REQ-006 SHIFT: each non-stalled cycle SHALL assert o_doShift=1, drive o_chainIn=tx byte bit[k] (LSB first), sample i_chainOut into rx bit[k], and increment the bit counter.
REQ-007 i_chainOut SHALL be sampled in the same cycle o_doShift is high, which captures the pre-edge chain output.
REQ-008 On the 8th bit of a byte, or on the final bit, the rx byte SHALL be pushed to o_rxData with o_rxValid=1.
- Next state is LOAD if bits remain, otherwise DONE.
REQ-009 Stall: if that final bit of a byte is reached while o_rxValid=1 and i_rxReady=0, the driver SHALL hold o_doShift=0 and hold all state until the holding register frees; no bit lost or duplicated.
REQ-010 A partial final rx byte SHALL have its unused upper bits equal to 0; unused tx bits SHALL be ignored.
REQ-011 DONE: o_done=1 for exactly one cycle, o_busy=0 in that cycle, then IDLE.
REQ-012 o_rxValid SHALL clear on the cycle after o_rxValid and i_rxReady are both 1, unless a new byte is pushed that same cycle.
REQ-013 o_chainIn=0 and o_doShift=0 in every non-shifting cycle.
REQ-014 o_busy=1 in LOAD and SHIFT.
REQ-015 o_canDrive SHALL be registered: it equals the previous cycle's i_driveReq AND (state==IDLE), so it is forced 0 throughout a transfer.
REQ-016 Minimum transfer time SHALL be 1 (start) + 9 per byte (1 LOAD + 8 SHIFT) + 1 (DONE) cycles.
REQ-017 i_abort SHALL return to IDLE next cycle from any state, clear o_rxValid, suppress o_done, and take priority over i_start.

Reset
REQ-018 With i_rstn=0 at a clock edge, the state SHALL go to IDLE and all outputs SHALL be 0: o_busy, o_done, o_txReady, o_rxData, o_rxValid, o_chainIn, o_doShift and o_canDrive.
REQ-019 Reset mid-transfer SHALL discard all partial data with no o_done; the first post-reset cycle SHALL accept i_start.

Configuration
REQ-020 With macro SCAN_CHAIN_DRIVER_LOOPBACK_EN defined, the block SHALL add input i_loopback (1 bit).
- When i_loopback=1, capture uses o_chainIn instead of i_chainOut, and o_doShift is held 0 so the chain is untouched.
- All other timing is unchanged.
REQ-021 Without the macro, the i_loopback port and its logic SHALL be absent and capture SHALL always use i_chainOut.

Verification
REQ-022 8-bit chain model preloaded with 0x3C, i_len=7, tx 0xA5 -> o_chainIn sequence 1,0,1,0,0,1,0,1; rx=0x3C; o_done at cycle 10 after start.
REQ-023 i_len=11, tx 0xFF,0x0F, chain preloaded all-ones -> rx bytes 0xFF then 0x0F; two LOAD phases; one o_done.
REQ-024 i_rxReady=0 for 5 cycles at the second byte boundary of a 24-bit transfer -> o_doShift low for exactly those 5 cycles; all 24 bits match the model.
REQ-025 i_abort at the 4th SHIFT cycle -> IDLE next cycle, o_busy=0, o_rxValid=0, no o_done; an immediate new transfer succeeds.
REQ-026 i_driveReq=1 while idle -> o_canDrive=1 one cycle later; i_start -> o_canDrive=0 from LOAD until after DONE, then 1 again.
REQ-027 Macro defined, i_loopback=1, tx 0x5A, i_len=7 -> rx=0x5A; o_doShift never asserted.
